// File: rtl/driver_display.sv
// driver_display: streams a 128x64 monochrome frame to an SSD1306 OLED over 4-wire SPI (mode 0).
// Ports: clk/rst (async active-high), imagem (8192-bit frame, byte k = imagem[8k+7:8k]),
//        spi_sclk/spi_mosi/spi_cs/spi_dc/spi_res to the panel, pronto (init done), quadro_enviado (frame pulse).
module driver_display #(
    parameter int DIV          = 4,
    parameter int ATRASO_RESET = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8191:0] imagem,
    output logic          spi_sclk,
    output logic          spi_mosi,
    output logic          spi_cs,
    output logic          spi_dc,
    output logic          spi_res,
    output logic          pronto,
    output logic          quadro_enviado
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW = (ATRASO_RESET > 1) ? $clog2(ATRASO_RESET + 1) : 1;

    typedef enum logic [2:0] {
        RES_DISP,
        ESPERA,
        INIT,
        CMD_QUADRO,
        DADOS
    } estado_t;

    estado_t         estado, estado_prox;
    logic [AW-1:0]   atraso_cnt;
    logic [DW-1:0]   div_cnt;
    logic            meia;          // 0 = SCLK-low half, 1 = SCLK-high half
    logic [3:0]      bit_cnt;       // 0..7 = bit slots (MSB first), 8 = inter-byte gap
    logic [9:0]      byte_idx;
    logic            pronto_q;
    logic [8191:0]   buffer;        // frame snapshot; shifted right one byte per data byte

    logic            engine;
    logic            fim_meia;
    logic            fim_byte;
    logic            atraso_fim;
    logic            ultimo;
    logic            cur_dado;
    logic            prox_dado;
    logic [7:0]      byte_atual;
    logic            bit_ativo;
    logic            captura;

    function automatic logic [7:0] init_rom(input logic [4:0] i);
        case (i)
            5'd0:  init_rom = 8'hAE;
            5'd1:  init_rom = 8'hD5;
            5'd2:  init_rom = 8'h80;
            5'd3:  init_rom = 8'hA8;
            5'd4:  init_rom = 8'h3F;
            5'd5:  init_rom = 8'hD3;
            5'd6:  init_rom = 8'h00;
            5'd7:  init_rom = 8'h40;
            5'd8:  init_rom = 8'h8D;
            5'd9:  init_rom = 8'h14;
            5'd10: init_rom = 8'h20;
            5'd11: init_rom = 8'h00;
            5'd12: init_rom = 8'hA1;
            5'd13: init_rom = 8'hC8;
            5'd14: init_rom = 8'hDA;
            5'd15: init_rom = 8'h12;
            5'd16: init_rom = 8'h81;
            5'd17: init_rom = 8'hCF;
            5'd18: init_rom = 8'hD9;
            5'd19: init_rom = 8'hF1;
            5'd20: init_rom = 8'hDB;
            5'd21: init_rom = 8'h40;
            5'd22: init_rom = 8'hA4;
            5'd23: init_rom = 8'hA6;
            5'd24: init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Column window 0..127, page window 0..7.
    function automatic logic [7:0] cmd_rom(input logic [2:0] i);
        case (i)
            3'd0: cmd_rom = 8'h21;
            3'd1: cmd_rom = 8'h00;
            3'd2: cmd_rom = 8'h7F;
            3'd3: cmd_rom = 8'h22;
            3'd4: cmd_rom = 8'h00;
            3'd5: cmd_rom = 8'h07;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    assign engine     = (estado == INIT) || (estado == CMD_QUADRO) || (estado == DADOS);
    assign fim_meia   = (div_cnt == DW'(DIV - 1));
    assign fim_byte   = engine && (bit_cnt == 4'd8) && meia && fim_meia;
    assign atraso_fim = (atraso_cnt == AW'(ATRASO_RESET - 1));
    // First cycle of CMD_QUADRO: the frame snapshot is taken here.
    assign captura    = (estado == CMD_QUADRO) && (byte_idx == 10'd0) && (bit_cnt == 4'd0)
                        && !meia && (div_cnt == '0);

    always_comb begin
        estado_prox = estado;
        byte_atual  = 8'h00;
        ultimo      = 1'b0;
        cur_dado    = 1'b0;
        prox_dado   = 1'b0;
        case (estado)
            RES_DISP: begin
                if (atraso_fim) estado_prox = ESPERA;
            end
            ESPERA: begin
                if (atraso_fim) estado_prox = INIT;
            end
            INIT: begin
                byte_atual = init_rom(byte_idx[4:0]);
                ultimo     = (byte_idx == 10'd24);
                if (fim_byte && ultimo) estado_prox = CMD_QUADRO;
            end
            CMD_QUADRO: begin
                byte_atual = cmd_rom(byte_idx[2:0]);
                ultimo     = (byte_idx == 10'd5);
                prox_dado  = ultimo;
                if (fim_byte && ultimo) estado_prox = DADOS;
            end
            DADOS: begin
                byte_atual = buffer[7:0];
                ultimo     = (byte_idx == 10'd1023);
                cur_dado   = 1'b1;
                prox_dado  = !ultimo;
                if (fim_byte && ultimo) estado_prox = CMD_QUADRO;
            end
            default: estado_prox = RES_DISP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= RES_DISP;
            atraso_cnt <= '0;
            div_cnt    <= '0;
            meia       <= 1'b0;
            bit_cnt    <= 4'd0;
            byte_idx   <= 10'd0;
            pronto_q   <= 1'b0;
        end else begin
            estado <= estado_prox;

            if ((estado == RES_DISP) || (estado == ESPERA))
                atraso_cnt <= atraso_fim ? '0 : atraso_cnt + AW'(1);
            else
                atraso_cnt <= '0;

            if (engine) begin
                if (fim_meia) begin
                    div_cnt <= '0;
                    meia    <= ~meia;
                    if (meia) bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
                if (fim_byte) byte_idx <= ultimo ? 10'd0 : byte_idx + 10'd1;
            end else begin
                div_cnt  <= '0;
                meia     <= 1'b0;
                bit_cnt  <= 4'd0;
                byte_idx <= 10'd0;
            end

            if ((estado == INIT) && fim_byte && ultimo) pronto_q <= 1'b1;
        end
    end

    // Datapath only: contents are irrelevant until the next snapshot.
    always_ff @(posedge clk) begin
        if (captura)
            buffer <= imagem;
        else if ((estado == DADOS) && fim_byte)
            buffer <= {8'h00, buffer[8191:8]};
    end

    assign bit_ativo      = engine && (bit_cnt < 4'd8);
    assign spi_cs         = !bit_ativo;
    assign spi_sclk       = bit_ativo && meia;
    assign spi_mosi       = bit_ativo && byte_atual[~bit_cnt[2:0]];
    assign spi_res        = (estado != RES_DISP);
    // D/C switches in the second half of the gap so it never moves near a CS edge.
    assign spi_dc         = (engine && (bit_cnt == 4'd8) && meia) ? prox_dado : cur_dado;
    assign pronto         = pronto_q;
    assign quadro_enviado = (estado == DADOS) && ultimo && fim_byte;

endmodule

// File: tb/tb_driver_display.sv
module tb_driver_display;

    localparam int A = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [8191:0] imagem;
    logic spi_sclk, spi_mosi, spi_cs, spi_dc, spi_res, pronto, quadro_enviado;
    logic sclk3, mosi3, cs3, dc3, res3, pronto3, quadro3;

    driver_display #(.DIV(1), .ATRASO_RESET(A)) dut (
        .clk(clk), .rst(rst), .imagem(imagem),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_dc(spi_dc),
        .spi_res(spi_res), .pronto(pronto), .quadro_enviado(quadro_enviado)
    );

    driver_display #(.DIV(3), .ATRASO_RESET(A)) dut3 (
        .clk(clk), .rst(rst), .imagem(imagem),
        .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_cs(cs3), .spi_dc(dc3),
        .spi_res(res3), .pronto(pronto3), .quadro_enviado(quadro3)
    );

    always #5 clk = ~clk;

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference stream: {dc, byte} in the order the panel must receive them.
    logic [8:0] exp_q[$];
    logic [7:0] init_b[25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                               8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                               8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_b[6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    task automatic push_init();
        for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_b[i]});
    endtask

    task automatic push_frame(input logic [8191:0] img);
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, win_b[i]});
        for (int k = 0; k < 1024; k++) exp_q.push_back({1'b1, img[8*k +: 8]});
    endtask

    // SPI monitor: reassembles bytes on SCLK rising edges and checks them against the reference.
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;
    logic       dc_ini    = 1'b0;
    logic [7:0] sh        = 8'h00;
    logic [8:0] ref_b;
    int         nbits     = 0;
    int         n_bytes   = 0;
    int         pronto_rise = -1;
    int         start_q[$];
    int         quadro_q[$];

    always @(negedge clk) begin
        if (rst) begin
            nbits       = 0;
            pronto_rise = -1;
            start_q.delete();
            quadro_q.delete();
        end else begin
            if (prev_cs && !spi_cs) begin
                start_q.push_back(ciclo);
                dc_ini = spi_dc;
            end
            if (!spi_cs) chk("dc_stable", {31'd0, spi_dc}, {31'd0, dc_ini});
            if (spi_sclk && !prev_sclk) begin
                sh = {sh[6:0], spi_mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    n_bytes++;
                    chk("stream_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        ref_b = exp_q.pop_front();
                        chk($sformatf("byte%0d", n_bytes), {23'd0, dc_ini, sh}, {23'd0, ref_b});
                    end
                end
            end
            if (quadro_enviado) quadro_q.push_back(ciclo);
            if (pronto && pronto_rise < 0) pronto_rise = ciclo;
        end
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs;
    end

    task automatic wait_bytes(input int n);
        int t = 0;
        while (n_bytes < n && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_bytes_%0d", n), {31'd0, n_bytes >= n}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_sclk"},   {31'd0, spi_sclk},       32'd0);
        chk({pfx, "_mosi"},   {31'd0, spi_mosi},       32'd0);
        chk({pfx, "_cs"},     {31'd0, spi_cs},         32'd1);
        chk({pfx, "_dc"},     {31'd0, spi_dc},         32'd0);
        chk({pfx, "_res"},    {31'd0, spi_res},        32'd0);
        chk({pfx, "_pronto"}, {31'd0, pronto},         32'd0);
        chk({pfx, "_quadro"}, {31'd0, quadro_enviado}, 32'd0);
    endtask

    // Counts spi_res low cycles, then high cycles with CS idle, from the release sample.
    task automatic check_power_up(input string pfx);
        int lo = 0;
        int hi = 0;
        while (spi_res === 1'b0 && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        while (spi_res === 1'b1 && spi_cs === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk({pfx, "_res_low"},  lo, A);
        chk({pfx, "_res_high"}, hi, A);
        chk({pfx, "_cs_fall"},  {31'd0, spi_cs}, 32'd0);
    endtask

    logic [8191:0] pat;
    int            nb0;

    initial begin
        for (int k = 0; k < 1024; k++) pat[8*k +: 8] = 8'(k);
        imagem = pat;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        push_init();
        push_frame(pat);
        rst = 1'b0;
        check_power_up("pwr");

        // Init: 25 bytes of 18 cycles each, pronto on the first CMD_QUADRO cycle.
        wait_bytes(26);
        if (start_q.size() > 25) begin
            chk("byte_period", start_q[1] - start_q[0], 18);
            chk("init_len",    start_q[25] - start_q[0], 25 * 18);
            chk("pronto_rise", pronto_rise - start_q[0], 25 * 18);
        end else chk("start_q_len_init", start_q.size(), 26);

        // Snapshot: zeros applied mid-frame 1 only affect frame 2.
        wait_bytes(25 + 6 + 500);
        imagem = '0;
        push_frame('0);
        wait_bytes(25 + 1030 + 1);
        chk("quadro_pulses", quadro_q.size(), 1);
        if (quadro_q.size() > 0 && start_q.size() > 25)
            chk("quadro_time", quadro_q[0] - start_q[25], 1030 * 18 - 1);
        if (start_q.size() > 1055)
            chk("frame_period", start_q[1055] - start_q[25], 1030 * 18);
        else chk("start_q_len_frame", start_q.size(), 1056);

        // Ones applied mid-frame 2 only affect frame 3.
        wait_bytes(25 + 1030 + 6 + 500);
        imagem = '1;
        push_frame('1);
        wait_bytes(25 + 2060 + 1);
        chk("quadro_pulses2", quadro_q.size(), 2);

        // Reset mid-bit during data byte 300 of frame 3.
        wait_bytes(25 + 2060 + 6 + 300);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) @(negedge clk);

        push_init();
        push_frame('1);
        nb0 = n_bytes;
        rst = 1'b0;
        check_power_up("pwr2");
        wait_bytes(nb0 + 26);
        if (start_q.size() > 25)
            chk("pronto_rise2", pronto_rise - start_q[0], 25 * 18);
        else chk("start_q_len_2", start_q.size(), 26);
        chk("exp_q_left", exp_q.size(), 25 + 1030 - 26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // DIV=3 instance: waveform timing of its first byte (AE).
    logic sc3[60];
    logic cs3s[60];
    logic mo3[60];

    initial begin
        int t = 0;
        int lo = 0;
        int hi = 0;
        int csl = 0;
        int csh = 0;
        logic [7:0] b3;
        @(negedge clk);
        while ((rst === 1'b1 || cs3 !== 1'b0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("div3_cs_seen", {31'd0, cs3}, 32'd0);
        for (int i = 0; i < 60; i++) begin
            sc3[i]  = sclk3;
            cs3s[i] = cs3;
            mo3[i]  = mosi3;
            @(negedge clk);
        end
        while (lo < 60 && sc3[lo] == 1'b0) lo++;
        while (lo + hi < 60 && sc3[lo + hi] == 1'b1) hi++;
        while (csl < 60 && cs3s[csl] == 1'b0) csl++;
        while (csl + csh < 60 && cs3s[csl + csh] == 1'b1) csh++;
        for (int b = 0; b < 8; b++) b3[7 - b] = mo3[6 * b + 3];
        chk("div3_sclk_low",  lo, 3);
        chk("div3_sclk_high", hi, 3);
        chk("div3_cs_low",    csl, 48);
        chk("div3_cs_gap",    csh, 6);
        chk("div3_period",    csl + csh, 54);
        chk("div3_byte",      {24'd0, b3}, 32'h0000_00AE);
    end

endmodule

// File: doc/driver_display.md
# driver_display

Downstream stage of the pet's image controller: consumes the 8192-bit `imagem` frame (128x64 monochrome, 1024 bytes) and streams it continuously to an SSD1306 OLED over 4-wire SPI. After reset it pulses the display reset line and sends a fixed init command sequence. It then loops forever: snapshot `imagem`, send the address-window commands, send 1024 data bytes. It is instantiated in the top level next to the image controller, with its SPI pins routed to the board.

## Interface
- `DIV`, default 4: clk cycles per SCLK half-period; must be ≥ 1.
- `ATRASO_RESET`, default 50000: clk cycles for each of the display-reset low phase and the post-reset wait; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `imagem`  in  8192  frame; byte k = `imagem[8k+7:8k]`, k = 0..1023.
- `spi_sclk`  out  1  SPI clock, mode 0 (idles low).
- `spi_mosi`  out  1  serial data, MSB first.
- `spi_cs`  out  1  chip select, active low.
- `spi_dc`  out  1  0 = command byte, 1 = data byte.
- `spi_res`  out  1  display reset, active low.
- `pronto`  out  1  high once init has completed; stays high until `rst`.
- `quadro_enviado`  out  1  one-cycle pulse after each complete frame.

## Operation
States:
- **RES_DISP**: `spi_res` = 0 for ATRASO_RESET cycles.
- **ESPERA**: `spi_res` = 1 for ATRASO_RESET cycles.
- **INIT**: send 25 command bytes (dc = 0) in this order: AE, D5, 80, A8, 3F, D3, 00, 40, 8D, 14, 20, 00, A1, C8, DA, 12, 81, CF, D9, F1, DB, 40, A4, A6, AF. After the last byte, `pronto` goes to 1.
- **CMD_QUADRO**: on entry, latch all 8192 bits of `imagem` into an internal buffer. Then send 6 command bytes (dc = 0): 21, 00, 7F, 22, 00, 07.
- **DADOS**: send buffer bytes k = 0..1023 in order with dc = 1. Byte k lands at page k/128, column k%128; bit 0 is the top pixel. After byte 1023, pulse `quadro_enviado` and return to CMD_QUADRO.

Byte transfer (shared engine):
- `spi_cs` = 0 and `spi_dc` valid for the whole byte.
- Per bit, MSB first:
  - `spi_mosi` is set while SCLK is low.
  - SCLK is low for DIV cycles, then high for DIV cycles; the display samples on the rising edge.
- After bit 0: `spi_cs` = 1, SCLK low, for 2·DIV cycles (the inter-byte gap). The next byte starts on the following cycle.
- One byte therefore takes exactly 18·DIV cycles.

Rules:
- Changes to `imagem` during CMD_QUADRO or DADOS have no effect until the next CMD_QUADRO entry, so there is no tearing within a frame.
- `spi_dc` changes only while `spi_cs` = 1.
- `rst` asserted at any point (mid-bit, mid-frame, mid-init) forces all outputs to their reset values asynchronously. When released, the sequence restarts at RES_DISP, including the full init.

## Timing
- Reset values: `spi_sclk`=0, `spi_mosi`=0, `spi_cs`=1, `spi_dc`=0, `spi_res`=0, `pronto`=0, `quadro_enviado`=0.
- First falling edge of `spi_cs` occurs 2·ATRASO_RESET cycles after `rst` deasserts (±1 cycle).
- Init duration: 25·18·DIV cycles.
- `pronto` rises on the cycle the INIT gap of the last byte ends, which is also the first cycle of CMD_QUADRO.
- Frame period (CMD_QUADRO entry to next entry): 1030·18·DIV cycles. At DIV=4 this is 74160 cycles.
- `quadro_enviado` is high for exactly one cycle, on the last cycle of byte 1023's inter-byte gap.
- Snapshot latency: `imagem` sampled on the CMD_QUADRO entry cycle appears on the wire starting 6·18·DIV cycles later.

## Test plan
- Reset values: assert `rst` with DIV=1, ATRASO_RESET=4 → all outputs at reset values. Release → `spi_res` low for 4 cycles, high for 4 cycles, then `spi_cs` falls.
- Init sequence: an SPI monitor samples MOSI on SCLK rising edges → the 25 bytes AE…AF in order, each with dc=0. Each byte spans 18 cycles. `pronto` rises after byte 25.
- Frame content: byte k of `imagem` = k[7:0] → monitor sees the commands 21 00 7F 22 00 07 (dc=0), then data 00, 01, …, FF repeated 4 times (dc=1). `quadro_enviado` pulses once, 1030·18 cycles after CMD_QUADRO entry.
- Snapshot: set `imagem` to all 00; change it to all FF at data byte 500 → the current frame is all 00, the next frame is all FF.
- Mid-operation reset: assert `rst` during data byte 300, mid-bit → `spi_cs`=1, `spi_sclk`=0, `pronto`=0 immediately. After release, the full RES_DISP/ESPERA/INIT sequence repeats.
- DIV scaling: DIV=3 → SCLK high 3 cycles and low 3 cycles, byte period 54 cycles, `spi_cs` gap 6 cycles.
